hall_call_latch: RTL and testbench



---
 rtl/hall_call_latch.sv | 78 +++++++
 tb/tb_hall_call_latch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hall_call_latch.sv
// Request-capture stage for the elevator controller: synchronise, debounce and edge-detect the raw
// buttons, then hold each accepted press as a sticky request until the controller clears it.
// Build option: define HALL_CALL_DEBOUNCE_EN to compile in the DB_CYCLES debounce filter.
module hall_call_latch #(
  parameter int NUM_BTN   = 7,
  parameter int DB_CYCLES = 1000,
  parameter int DB_W      = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] clr,
  output logic [NUM_BTN-1:0] req,
  output logic [NUM_BTN-1:0] lamp,
  output logic [NUM_BTN-1:0] press_pulse
);

  // Refuse to elaborate configurations the bit map or the counter cannot represent.
  if (NUM_BTN != 7 || DB_CYCLES < 1 || DB_CYCLES >= (1 << DB_W)) begin : g_bad_cfg
    $error("hall_call_latch: unsupported NUM_BTN/DB_CYCLES/DB_W combination");
  end

  logic [NUM_BTN-1:0] s1;
  logic [NUM_BTN-1:0] s2;
  logic [NUM_BTN-1:0] db;
  logic [NUM_BTN-1:0] db_d;

  // NOTE: sequential blocks use <= so every flop samples pre-edge values; with = the second
  // synchroniser stage would collapse into the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      db_d <= '0;
      req  <= '0;
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      db_d <= db;
      // clr wins: a press landing while the controller services that button is dropped.
      req  <= ~clr & (req | press_pulse);
    end
  end

`ifdef HALL_CALL_DEBOUNCE_EN
  logic [DB_W-1:0] cnt [NUM_BTN];

  // db flips only after s2 has disagreed with it for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) db <= '0;
    else        db <= s2;
  end
`endif

  // NOTE: press_pulse is a pure AND of two registers, so it is glitch-free within the cycle
  // and needs no flop of its own.
  assign press_pulse = db & ~db_d;
  assign lamp        = req;

endmodule

// File: tb/tb_hall_call_latch.sv
// Self-checking bench for hall_call_latch: directed steps from the test plan followed by random
// button/clear/reset traffic, all compared every cycle against a window-based reference model.
module tb_hall_call_latch;

  localparam int DBC = 4;
  localparam int DBW = 10;
`ifdef HALL_CALL_DEBOUNCE_EN
  localparam int N = DBC;
`else
  localparam int N = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] btn_raw;
  logic [6:0] clr;
  logic [6:0] req;
  logic [6:0] lamp;
  logic [6:0] press_pulse;

  hall_call_latch #(.NUM_BTN(7), .DB_CYCLES(DBC), .DB_W(DBW)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .clr(clr),
    .req(req), .lamp(lamp), .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a button's debounced level becomes the opposite value once the last N
  // synchronised samples all showed that opposite value.
  logic [6:0] s1m, s2m, dbm, dbdm, reqm;
  logic [6:0] hist [N];

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    s1m = '0; s2m = '0; dbm = '0; dbdm = '0; reqm = '0;
    for (int i = 0; i < N; i++) hist[i] = '0;
  endtask

  task automatic model_edge();
    logic [6:0] pp, db_n;
    pp = dbm & ~dbdm;
    for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s2m;
    for (int b = 0; b < 7; b++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int i = 0; i < N; i++) if (hist[i][b] == dbm[b]) all_diff = 1'b0;
      db_n[b] = all_diff ? ~dbm[b] : dbm[b];
    end
    reqm = clr & 7'h00 | (~clr & (reqm | pp));
    dbdm = dbm;
    dbm  = db_n;
    s2m  = s1m;
    s1m  = btn_raw;
  endtask

  task automatic check_all();
    check("req", req, reqm);
    check("lamp", lamp, reqm);
    check("press_pulse", press_pulse, dbm & ~dbdm);
  endtask

  // One clock: model follows the DUT at the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Counts edges from now until req[b] rises; a run past the bound is reported as a failure.
  task automatic latency(input int b, input int bound, output int edges);
    edges = -1;
    for (int i = 1; i <= bound; i++) begin
      cycle();
      if (edges < 0 && req[b]) edges = i;
    end
  endtask

  initial begin
    int lat;
    model_reset();

    // 1: reset with every button pressed, release with buttons idle.
    rst_n = 1'b0; btn_raw = 7'h7F; clr = '0;
    #1 check_all();
    cycles(3);
    rst_n = 1'b1; btn_raw = '0;
    cycles(N + 6);
    check("idle_after_reset", req, 7'h00);

    // 2: clean press of floor1button, pulse after edge 2+N, request from edge 3+N.
    btn_raw[4] = 1'b1;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      check("pulse4_timing", {6'b0, press_pulse[4]}, {6'b0, i == 2 + N});
      if (lat < 0 && req[4]) lat = i;
    end
    check("latency4", 7'(lat), 7'(3 + N));
    btn_raw[4] = 1'b0;
    cycles(N + 4);
    check("req4_sticky", req, 7'h10);

    // 4: clr while button held does not re-latch; a fresh press does.
    btn_raw[4] = 1'b1;
    cycles(N + 4);
    clr[4] = 1'b1;
    cycle();
    check("req4_cleared", req, 7'h00);
    clr[4] = 1'b0;
    cycles(N + 6);
    check("req4_no_relatch", req, 7'h00);
    btn_raw[4] = 1'b0;
    cycles(N + 4);
    btn_raw[4] = 1'b1;
    latency(4, 3 * N + 10, lat);
    check("latency4_again", 7'(lat), 7'(N + 3));
    btn_raw[4] = 1'b0;
    cycles(N + 4);

    // 3: bouncy 3-1-3 pattern on floor2up, then a clean press.
    for (int i = 0; i < 7; i++) begin
      btn_raw[2] = (i != 3);
      cycle();
    end
    btn_raw[2] = 1'b0;
    cycles(N + 4);
`ifdef HALL_CALL_DEBOUNCE_EN
    check("bounce_rejected", req, 7'h10);
`endif
    btn_raw[2] = 1'b1;
    cycles(N + 4);
    btn_raw[2] = 1'b0;
    cycles(N + 2);
    check("req2_latched", req, 7'h14);
    clr = 7'h7F;
    cycle();
    clr = '0;

    // 5: clr[6] held across press_pulse[6] while button 0 latches normally.
    clr[6] = 1'b1;
    btn_raw[6] = 1'b1; btn_raw[0] = 1'b1;
    cycles(N + 6);
    check("clr_priority", req, 7'h01);
    btn_raw = '0;
    cycles(N + 4);
    clr = '0;
    cycles(N + 4);
    check("req6_dropped", req, 7'h01);

    // 6: reset in the middle of a request with a button held clears everything at once.
    btn_raw[1] = 1'b1;
    cycles(N + 4);
    rst_n = 1'b0;
    #1 model_reset();
    check("async_reset", req, 7'h00);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    latency(1, 3 * N + 10, lat);
    check("held_after_reset", 7'(lat), 7'(N + 3));
    btn_raw = '0;

    // Random traffic: bouncing buttons, sporadic clears and the odd reset.
    for (int k = 0; k < 400; k++) begin
      for (int b = 0; b < 7; b++) begin
        if ($urandom_range(5) == 0) btn_raw[b] = ~btn_raw[b];
        clr[b] = ($urandom_range(9) == 0);
      end
      if ($urandom_range(149) == 0) begin
        rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
